multi_mode_trigger_fsm: RTL and testbench

- Parametrised successor to the fixed-length IDLE/ACTIVE/DONE trigger FSM.
- Detects a selectable edge on an external trigger, then holds `active` for a run-time length, then `done` for a parameterised width, then returns to idle.
- Adds retrigger mode, abort, a busy flag and a remaining-count output.
- Used as a generic pulse/window generator driven from control logic in the clock-driven module set.

---
 rtl/multi_mode_trigger_fsm.sv | 124 ++++++++++++
 tb/tb_multi_mode_trigger_fsm.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/multi_mode_trigger_fsm.sv
// Multi-mode trigger FSM: detects a selectable trigger edge, holds `active`
// for a run-time length, then `done` for DONE_LEN cycles, then returns to idle.
// Supports retrigger, abort, busy flag and a remaining-cycle count.
module multi_mode_trigger_fsm #(
  parameter int CNT_W     = 8,
  parameter int DONE_LEN  = 1,
  parameter int EDGE_SEL  = 0,
  parameter int RETRIGGER = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             trigger,
  input  logic             abort,
  input  logic [CNT_W-1:0] len,
  output logic             active,
  output logic             done,
  output logic             busy,
  output logic             aborted,
  output logic [CNT_W-1:0] remaining
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam logic [7:0] DONE_LOAD = 8'(DONE_LEN - 1);

  logic [1:0]       state_q, state_d;
  logic             trig_prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       dcnt_q, dcnt_d;
  logic             aborted_q, aborted_d;

  logic             rise, fall, trig_edge;
  logic [CNT_W-1:0] load_val;

  // Edge qualification against the previous trigger level
  always_comb begin
    rise = trigger & ~trig_prev_q;
    fall = ~trigger & trig_prev_q;
    case (EDGE_SEL)
      0:       trig_edge = rise;
      1:       trig_edge = fall;
      default: trig_edge = rise | fall;
    endcase
    // A length of zero behaves as one cycle, so the counter loads L-1
    load_val = (len == '0) ? '0 : (len - CNT_W'(1));
  end

  // State, counters, trigger history and abort pulse registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      trig_prev_q <= 1'b0;
      cnt_q       <= '0;
      dcnt_q      <= '0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      trig_prev_q <= trigger;
      cnt_q       <= cnt_d;
      dcnt_q      <= dcnt_d;
      aborted_q   <= aborted_d;
    end
  end

  // Next-state and counter logic; abort outranks end-of-count and retrigger
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dcnt_d    = dcnt_q;
    aborted_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (trig_edge && !abort) begin
          state_d = S_ACTIVE;
          cnt_d   = load_val;
        end
      end
      S_ACTIVE: begin
        if (abort) begin
          state_d   = S_IDLE;
          cnt_d     = '0;
          dcnt_d    = '0;
          aborted_d = 1'b1;
        end else if ((RETRIGGER != 0) && trig_edge) begin
          cnt_d = load_val;
        end else if (cnt_q == '0) begin
          state_d = S_DONE;
          dcnt_d  = DONE_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DONE: begin
        if (abort) begin
          state_d   = S_IDLE;
          cnt_d     = '0;
          dcnt_d    = '0;
          aborted_d = 1'b1;
        end else if (dcnt_q == 8'd0) begin
          state_d = S_IDLE;
        end else begin
          dcnt_d = dcnt_q - 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        dcnt_d  = '0;
      end
    endcase
  end

  // Outputs decoded from the registered state
  always_comb begin
    active    = (state_q == S_ACTIVE);
    done      = (state_q == S_DONE);
    busy      = active | done;
    aborted   = aborted_q;
    remaining = active ? cnt_q : '0;
  end

endmodule

// File: tb/tb_multi_mode_trigger_fsm.sv
// Bench for multi_mode_trigger_fsm: three parameter variants share one
// stimulus stream and are compared every cycle against a window-count model.
module tb_multi_mode_trigger_fsm;

  logic       clk = 1'b0;
  logic       reset, trigger, abort;
  logic [7:0] len;

  logic       act [3];
  logic       dn  [3];
  logic       bsy [3];
  logic       abd [3];
  logic [7:0] rem [3];

  int n_chk  = 0;
  int n_fail = 0;

  // Variant configuration: DONE_LEN, EDGE_SEL, RETRIGGER
  int cfg_dl [3] = '{1, 3, 4};
  int cfg_es [3] = '{0, 2, 1};
  int cfg_rt [3] = '{0, 1, 0};

  // Model: cycles of active / done still to show, including the current one
  int m_act_left  [3];
  int m_done_left [3];
  bit m_prev      [3];
  bit m_ab        [3];

  always #5 clk = ~clk;

  multi_mode_trigger_fsm #(.CNT_W(8), .DONE_LEN(1), .EDGE_SEL(0), .RETRIGGER(0)) u_a (
    .clk(clk), .reset(reset), .trigger(trigger), .abort(abort), .len(len),
    .active(act[0]), .done(dn[0]), .busy(bsy[0]), .aborted(abd[0]), .remaining(rem[0]));

  multi_mode_trigger_fsm #(.CNT_W(8), .DONE_LEN(3), .EDGE_SEL(2), .RETRIGGER(1)) u_b (
    .clk(clk), .reset(reset), .trigger(trigger), .abort(abort), .len(len),
    .active(act[1]), .done(dn[1]), .busy(bsy[1]), .aborted(abd[1]), .remaining(rem[1]));

  multi_mode_trigger_fsm #(.CNT_W(8), .DONE_LEN(4), .EDGE_SEL(1), .RETRIGGER(0)) u_c (
    .clk(clk), .reset(reset), .trigger(trigger), .abort(abort), .len(len),
    .active(act[2]), .done(dn[2]), .busy(bsy[2]), .aborted(abd[2]), .remaining(rem[2]));

  task automatic check(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s dut%0d: observed %0d expected %0d", tag, k, obs, exp);
    end
  endtask

  // Advance the reference model by one clock using the inputs held at the edge
  task automatic step_model(input bit r, input bit t, input bit a, input int l);
    for (int k = 0; k < 3; k++) begin
      int  win;
      bit  rise, fall, e;
      win = (l == 0) ? 1 : l;
      if (r) begin
        m_act_left[k]  = 0;
        m_done_left[k] = 0;
        m_prev[k]      = 0;
        m_ab[k]        = 0;
      end else begin
        rise = t && !m_prev[k];
        fall = !t && m_prev[k];
        e = (cfg_es[k] == 0) ? rise : (cfg_es[k] == 1) ? fall : (rise || fall);
        m_ab[k] = 0;
        if (m_act_left[k] > 0) begin
          if (a) begin
            m_act_left[k] = 0;
            m_ab[k]       = 1;
          end else if (cfg_rt[k] != 0 && e) begin
            m_act_left[k] = win;
          end else begin
            m_act_left[k]--;
            if (m_act_left[k] == 0) m_done_left[k] = cfg_dl[k];
          end
        end else if (m_done_left[k] > 0) begin
          if (a) begin
            m_done_left[k] = 0;
            m_ab[k]        = 1;
          end else begin
            m_done_left[k]--;
          end
        end else if (e && !a) begin
          m_act_left[k] = win;
        end
        m_prev[k] = t;
      end
    end
  endtask

  // Apply one cycle of stimulus, clock it, then compare every variant
  task automatic tick(input bit r, input bit t, input bit a, input int l);
    reset   = r;
    trigger = t;
    abort   = a;
    len     = 8'(l);
    @(posedge clk);
    step_model(r, t, a, l);
    #1;
    for (int k = 0; k < 3; k++) begin
      check("active",    k, {31'd0, act[k]}, {31'd0, m_act_left[k] > 0});
      check("done",      k, {31'd0, dn[k]},  {31'd0, m_done_left[k] > 0});
      check("busy",      k, {31'd0, bsy[k]}, {31'd0, (m_act_left[k] > 0) || (m_done_left[k] > 0)});
      check("aborted",   k, {31'd0, abd[k]}, {31'd0, m_ab[k]});
      check("remaining", k, {24'd0, rem[k]}, (m_act_left[k] > 0) ? m_act_left[k] - 1 : 0);
    end
  endtask

  task automatic hold(input int n, input bit t, input int l);
    for (int i = 0; i < n; i++) tick(0, t, 0, l);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      m_act_left[k] = 0; m_done_left[k] = 0; m_prev[k] = 0; m_ab[k] = 0;
    end
    reset = 1'b1; trigger = 1'b0; abort = 1'b0; len = 8'd0;

    // Reset state
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);

    // Basic window, len=4, trigger held high then released
    tick(0, 1, 0, 4);
    hold(9, 1, 4);
    hold(12, 0, 4);

    // len=0 treated as a single active cycle
    tick(0, 1, 0, 0);
    hold(12, 0, 0);

    // Full-scale length, no wrap
    tick(0, 1, 0, 255);
    hold(270, 0, 255);

    // Second rising edge when remaining reads 2
    tick(0, 1, 0, 6);
    hold(3, 0, 6);
    tick(0, 1, 0, 6);
    hold(18, 0, 6);

    // Abort on the second active cycle
    tick(0, 1, 0, 5);
    tick(0, 0, 0, 5);
    tick(0, 0, 1, 5);
    hold(12, 0, 5);

    // Abort coincident with edges in idle
    tick(0, 1, 1, 3);
    tick(0, 0, 1, 3);
    hold(8, 0, 3);

    // Reset in the middle of the 4-cycle done phase of the fall-edge variant
    tick(0, 1, 0, 2);
    tick(0, 0, 0, 2);
    hold(3, 0, 2);
    tick(1, 0, 0, 2);
    hold(10, 0, 2);

    // Trigger held high across reset release, then dropped
    tick(1, 1, 0, 3);
    tick(1, 1, 0, 3);
    hold(10, 1, 3);
    hold(12, 0, 3);

    // Randomised traffic
    begin
      bit t;
      t = 0;
      for (int i = 0; i < 3000; i++) begin
        bit r, a;
        int l;
        r = ($urandom_range(0, 199) == 0);
        a = ($urandom_range(0, 24) == 0);
        if ($urandom_range(0, 3) == 0) t = ~t;
        l = ($urandom_range(0, 49) == 0) ? 255 : $urandom_range(0, 12);
        tick(r, t, a, l);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
